// File: rtl/memory_unit.sv
// MEM stage of the 16-bit pipeline: 16-line data memory, loads/stores, ALU pass-through,
// and a registered write-back bundle for WB.
module memory_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clkwire,
  input  logic              resetn,
  input  logic [3:0]        instruction,
  input  logic [ADDR_W-1:0] linenum,
  input  logic [DATA_W-1:0] aluoutput,
  input  logic [REG_W-1:0]  registernum,
  output logic [DATA_W-1:0] writedata,
  output logic              checkwritedata,
  output logic [REG_W-1:0]  regnum
);

  localparam logic [3:0] OpNop   = 4'b0000;
  localparam logic [3:0] OpLoad  = 4'b0001;
  localparam logic [3:0] OpStore = 4'b0010;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [REG_W-1:0]  regnum_q, regnum_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_we;

  // Non-writeback opcodes leave writedata/regnum untouched so WB sees stable values.
  always_comb begin
    writedata_d = writedata_q;
    regnum_d    = regnum_q;
    wb_en_d     = 1'b0;
    mem_we      = 1'b0;
    case (instruction)
      OpNop: ;
      OpLoad: begin
        writedata_d = mem_q[linenum];
        regnum_d    = registernum;
        wb_en_d     = 1'b1;
      end
      OpStore: mem_we = 1'b1;
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
        writedata_d = aluoutput;
        regnum_d    = registernum;
        wb_en_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkwire or negedge resetn) begin
    if (!resetn) begin
      writedata_q <= '0;
      regnum_q    <= '0;
      wb_en_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      writedata_q <= writedata_d;
      regnum_q    <= regnum_d;
      wb_en_q     <= wb_en_d;
      if (mem_we) begin
        mem_q[linenum] <= aluoutput;
      end
    end
  end

  assign writedata      = writedata_q;
  assign regnum         = regnum_q;
  assign checkwritedata = wb_en_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit: reset, ALU pass-through, store/load,
// boundary lines, non-writeback opcodes and asynchronous reset mid-stream.
module tb_memory_unit;

  logic        clkwire;
  logic        resetn;
  logic [3:0]  instruction;
  logic [3:0]  linenum;
  logic [15:0] aluoutput;
  logic [3:0]  registernum;
  logic [15:0] writedata;
  logic        checkwritedata;
  logic [3:0]  regnum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_model [16];

  memory_unit dut (
    .clkwire       (clkwire),
    .resetn        (resetn),
    .instruction   (instruction),
    .linenum       (linenum),
    .aluoutput     (aluoutput),
    .registernum   (registernum),
    .writedata     (writedata),
    .checkwritedata(checkwritedata),
    .regnum        (regnum)
  );

  initial clkwire = 1'b0;
  always #5 clkwire = ~clkwire;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction, let it be sampled on the next rising edge, return 1 time unit later.
  task automatic step(input logic [3:0] inst, input logic [3:0] line, input logic [15:0] alu,
                      input logic [3:0] rd);
    instruction = inst;
    linenum     = line;
    aluoutput   = alu;
    registernum = rd;
    @(posedge clkwire);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [15:0] wd, input logic [3:0] rd,
                          input logic en);
    check({tag, ".wd"}, 32'(writedata), 32'(wd));
    check({tag, ".reg"}, 32'(regnum), 32'(rd));
    check({tag, ".en"}, 32'(checkwritedata), 32'(en));
  endtask

  initial begin
    resetn      = 1'b0;
    instruction = 4'b0000;
    linenum     = '0;
    aluoutput   = '0;
    registernum = '0;
    for (int i = 0; i < 16; i++) mem_model[i] = 16'h0000;

    // 1. Reset holds outputs at zero even across edges carrying an ALU op.
    #2;
    check_wb("reset", 16'h0000, 4'd0, 1'b0);
    step(4'b0011, 4'd1, 16'hABCD, 4'd5);
    step(4'b0011, 4'd1, 16'hABCD, 4'd5);
    check_wb("reset_edge", 16'h0000, 4'd0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(4'b0001, 4'(i), 16'h5A5A, 4'(15 - i));
      check($sformatf("rst_load%0d", i), 32'(writedata), 32'h0);
    end
    check("rst_load_reg", 32'(regnum), 32'd0);
    check("rst_load_en", 32'(checkwritedata), 32'd1);

    // 2. ALU pass-through, memory untouched.
    step(4'b0011, 4'd9, 16'h0005, 4'd6);
    check_wb("alu", 16'h0005, 4'd6, 1'b1);
    step(4'b0001, 4'd9, 16'hFFFF, 4'd1);
    check_wb("alu_mem9", 16'h0000, 4'd1, 1'b1);
    step(4'b0111, 4'd2, 16'h8000, 4'd15);
    check_wb("alu_0111", 16'h8000, 4'd15, 1'b1);

    // 3. Store then load the same line on the very next cycle.
    step(4'b0010, 4'd3, 16'h000B, 4'd7);
    mem_model[3] = 16'h000B;
    check_wb("store", 16'h8000, 4'd15, 1'b0);
    step(4'b0001, 4'd3, 16'h0000, 4'd2);
    check_wb("st_ld", 16'h000B, 4'd2, 1'b1);

    // 4. Boundary lines, then every line against the model.
    step(4'b0010, 4'd15, 16'hFFFF, 4'd0);
    mem_model[15] = 16'hFFFF;
    step(4'b0010, 4'd0, 16'h8001, 4'd0);
    mem_model[0] = 16'h8001;
    step(4'b0001, 4'd15, 16'h0000, 4'd4);
    check_wb("ld15", 16'hFFFF, 4'd4, 1'b1);
    step(4'b0001, 4'd0, 16'h0000, 4'd8);
    check_wb("ld0", 16'h8001, 4'd8, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(4'b0001, 4'(i), 16'h1111, 4'(i));
      check($sformatf("scan%0d", i), 32'(writedata), 32'(mem_model[i]));
    end

    // 5. NOP and branch opcode: no write-back, outputs hold, memory unchanged.
    step(4'b0000, 4'd5, 16'h1234, 4'd9);
    check_wb("nop", 16'hFFFF, 4'd15, 1'b0);
    step(4'b1010, 4'd5, 16'h4321, 4'd3);
    check_wb("br", 16'hFFFF, 4'd15, 1'b0);
    step(4'b1111, 4'd6, 16'h2222, 4'd2);
    check_wb("rsvd", 16'hFFFF, 4'd15, 1'b0);
    step(4'b0001, 4'd5, 16'h0000, 4'd10);
    check_wb("nop_mem5", 16'h0000, 4'd10, 1'b1);
    step(4'b0001, 4'd6, 16'h0000, 4'd11);
    check_wb("nop_mem6", 16'h0000, 4'd11, 1'b1);

    // 6. Asynchronous reset between edges during a load sequence.
    step(4'b0010, 4'd7, 16'h7777, 4'd0);
    step(4'b0001, 4'd7, 16'h0000, 4'd12);
    check_wb("pre_arst", 16'h7777, 4'd12, 1'b1);
    instruction = 4'b0001;
    linenum     = 4'd3;
    registernum = 4'd13;
    #2;
    resetn = 1'b0;
    #1;
    check_wb("arst", 16'h0000, 4'd0, 1'b0);
    #1;
    instruction = 4'b0000;
    resetn      = 1'b1;
    step(4'b0001, 4'd3, 16'h0000, 4'd1);
    check_wb("post3", 16'h0000, 4'd1, 1'b1);
    step(4'b0001, 4'd7, 16'h0000, 4'd2);
    check("post7", 32'(writedata), 32'h0);
    step(4'b0001, 4'd15, 16'h0000, 4'd3);
    check("post15", 32'(writedata), 32'h0);
    step(4'b0001, 4'd0, 16'h0000, 4'd4);
    check("post0", 32'(writedata), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
